// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for the 16-bit RISC core. Each instruction is walked
//   through FETCH / DECODE / execute / writeback states. Memory accesses use a
//   req/ready handshake with an optional per-access timeout. Also provides
//   sticky halt/fault status and a retired-instruction counter.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   opcode       IR opcode field (low 4 bits decoded), valid from DECODE on
//   zero         ALU zero flag, used in BRANCH
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory request
//   mem_we       memory write enable
//   iord         address select (0 = PC, 1 = ALU result)
//   ir_write     IR load
//   pc_write     PC load
//   pc_src       00 = PC+2, 01 = branch target, 10 = jump target
//   reg_w        register file write
//   reg_dst      write-register select (1 = rd, 0 = rt)
//   mem_to_reg   writeback data select (1 = memory)
//   alu_src      ALU B select (1 = immediate)
//   alu_op       00 = add, 01 = sub, 10 = function from opcode
//   halted       sticky halt status
//   fault        sticky fault status (illegal opcode or memory timeout)
//   state        current state encoding
//   instr_count  retired instructions, wraps modulo 2^CNT_W
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | after reset, all outputs low
// FETCH   | read instruction at PC, load IR and PC+2 on ready
// DECODE  | dispatch on opcode
// ADDR    | compute load/store address (base + imm)
// MEM_RD  | load data read, address from ALU
// LW_WB   | write loaded data to rt
// MEM_WR  | store data write, address from ALU
// EXEC_R  | R-type ALU operation
// R_WB    | write ALU result to rd
// BRANCH  | compare, load branch target if condition holds
// JUMP    | load jump target
// HALT    | stopped until reset
// FAULT   | stopped until reset (illegal opcode / timeout)

module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_w,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_ADDR   = 4'h3,
    S_MEM_RD = 4'h4,
    S_LW_WB  = 4'h5,
    S_MEM_WR = 4'h6,
    S_EXEC_R = 4'h7,
    S_R_WB   = 4'h8,
    S_BRANCH = 4'h9,
    S_JUMP   = 4'hA,
    S_HALT   = 4'hB,
    S_FAULT  = 4'hC
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h0;
  localparam logic [3:0] OP_SW   = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_J    = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Moore outputs, registered from the next state so they line up with the
  // state register without a decode stage after it.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] pc_src;
    logic       reg_w;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       halted;
    logic       fault;
  } moore_t;

  function automatic moore_t moore_of(input state_t s);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:  m.mem_req = 1'b1;
      S_ADDR: begin
        m.alu_src = 1'b1;
        m.alu_op  = 2'b00;
      end
      S_MEM_RD: begin
        m.mem_req = 1'b1;
        m.iord    = 1'b1;
      end
      S_LW_WB: begin
        m.reg_w      = 1'b1;
        m.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        m.mem_req = 1'b1;
        m.mem_we  = 1'b1;
        m.iord    = 1'b1;
      end
      S_EXEC_R: m.alu_op = 2'b10;
      S_R_WB: begin
        m.reg_w   = 1'b1;
        m.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        m.alu_op = 2'b01;
        m.pc_src = 2'b01;
      end
      S_JUMP:   m.pc_src = 2'b10;
      S_HALT:   m.halted = 1'b1;
      S_FAULT:  m.fault  = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  state_t              state_q;
  state_t              nxt;
  moore_t              out_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [3:0]          op;
  logic                is_rtype;
  logic                mem_state;
  logic                waiting;
  logic                timeout_hit;
  logic                retire;
  logic                branch_taken;

  assign op           = opcode[3:0];
  assign is_rtype     = (op >= 4'h2) && (op <= 4'h9);
  assign mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);
  assign waiting      = mem_state && !mem_ready;
  // The limit is checked against the count before this cycle's increment, so
  // the access faults on the edge ending its TIMEOUT-th wait cycle.
  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign branch_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);

  assign retire = (state_q == S_LW_WB) || (state_q == S_R_WB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        nxt = S_DECODE;
        else if (timeout_hit) nxt = S_FAULT;
      end
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) nxt = S_ADDR;
        else if (is_rtype)                  nxt = S_EXEC_R;
        else if ((op == OP_BEQ) || (op == OP_BNE)) nxt = S_BRANCH;
        else if (op == OP_J)                nxt = S_JUMP;
        else if (op == OP_HALT)             nxt = S_HALT;
        else                                nxt = S_FAULT;
      end
      S_ADDR:   nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)        nxt = S_LW_WB;
        else if (timeout_hit) nxt = S_FAULT;
      end
      S_LW_WB:  nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)        nxt = S_FETCH;
        else if (timeout_hit) nxt = S_FAULT;
      end
      S_EXEC_R: nxt = S_R_WB;
      S_R_WB:   nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state_q  <= nxt;
      out_q    <= moore_of(nxt);
      // Counter is zero whenever an access starts because it clears on every
      // non-waiting cycle, including the one that leads into the access.
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

  assign mem_req    = out_q.mem_req;
  assign mem_we     = out_q.mem_we;
  assign iord       = out_q.iord;
  assign pc_src     = out_q.pc_src;
  assign reg_w      = out_q.reg_w;
  assign reg_dst    = out_q.reg_dst;
  assign mem_to_reg = out_q.mem_to_reg;
  assign alu_src    = out_q.alu_src;
  assign alu_op     = out_q.alu_op;
  assign halted     = out_q.halted;
  assign fault      = out_q.fault;
  assign state      = state_q;

  // Only these two strobes look at inputs directly.
  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign pc_write = ((state_q == S_FETCH) && mem_ready) ||
                    (state_q == S_JUMP) ||
                    ((state_q == S_BRANCH) && branch_taken);

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [3:0] IDLE = 4'h0, FETCH = 4'h1, DECODE = 4'h2, ADDR = 4'h3,
                         MEM_RD = 4'h4, LW_WB = 4'h5, MEM_WR = 4'h6,
                         EXEC_R = 4'h7, R_WB = 4'h8, BRANCH = 4'h9,
                         JUMP = 4'hA, HALT = 4'hB, FAULT = 4'hC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready, zero;
  logic [3:0] opcode;

  // u_a: TIMEOUT=4, CNT_W=16.  u_b: default TIMEOUT, CNT_W=2.
  logic        a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write;
  logic [1:0]  a_pc_src, a_alu_op;
  logic        a_reg_w, a_reg_dst, a_mem_to_reg, a_alu_src, a_halted, a_fault;
  logic [3:0]  a_state;
  logic [15:0] a_count;
  logic        b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write;
  logic [1:0]  b_pc_src, b_alu_op;
  logic        b_reg_w, b_reg_dst, b_mem_to_reg, b_alu_src, b_halted, b_fault;
  logic [3:0]  b_state;
  logic [1:0]  b_count;
  logic [14:0] a_ctl, b_ctl;

  assign a_ctl = {a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_pc_src,
                  a_reg_w, a_reg_dst, a_mem_to_reg, a_alu_src, a_alu_op,
                  a_halted, a_fault};
  assign b_ctl = {b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_pc_src,
                  b_reg_w, b_reg_dst, b_mem_to_reg, b_alu_src, b_alu_op,
                  b_halted, b_fault};

  multicycle_control #(.OPCODE_W(4), .CNT_W(16), .TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .iord(a_iord), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .pc_src(a_pc_src), .reg_w(a_reg_w), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .alu_src(a_alu_src), .alu_op(a_alu_op),
    .halted(a_halted), .fault(a_fault), .state(a_state),
    .instr_count(a_count)
  );

  multicycle_control #(.OPCODE_W(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .iord(b_iord), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .pc_src(b_pc_src), .reg_w(b_reg_w), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .alu_src(b_alu_src), .alu_op(b_alu_op),
    .halted(b_halted), .fault(b_fault), .state(b_state),
    .instr_count(b_count)
  );

  typedef struct {
    logic       rst_n;
    logic       mr;
    logic       z;
    logic [3:0] op;
  } stim_t;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [15:0] cnt;
    bit          chk_b;
    int          id;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          rec_id   = 0;
  logic [15:0] cnt_m    = 16'd0;
  bit          chk_b    = 1'b1;

  // Expected control vector for a state, from the output table of the unit.
  function automatic logic [14:0] model(input logic [3:0] st, input logic mr,
                                        input logic [3:0] op, input logic z);
    logic req, we, io, irw, pcw, rw, rd, m2r, asrc, hlt, flt;
    logic [1:0] psrc, aop;
    {req, we, io, irw, pcw, rw, rd, m2r, asrc, hlt, flt} = '0;
    psrc = 2'b00;
    aop  = 2'b00;
    case (st)
      FETCH:  begin req = 1; irw = mr; pcw = mr; end
      ADDR:   asrc = 1;
      MEM_RD: begin req = 1; io = 1; end
      LW_WB:  begin rw = 1; m2r = 1; end
      MEM_WR: begin req = 1; we = 1; io = 1; end
      EXEC_R: aop = 2'b10;
      R_WB:   begin rw = 1; rd = 1; end
      BRANCH: begin
        aop = 2'b01; psrc = 2'b01;
        pcw = ((op == 4'hB) && z) || ((op == 4'hC) && !z);
      end
      JUMP:   begin pcw = 1; psrc = 2'b10; end
      HALT:   hlt = 1;
      FAULT:  flt = 1;
      default: ;
    endcase
    return {req, we, io, irw, pcw, psrc, rw, rd, m2r, asrc, aop, hlt, flt};
  endfunction

  task automatic sched(input logic [3:0] st, input logic r, input logic mr,
                       input logic [3:0] op, input logic z);
    stim_t s;
    exp_t  e;
    s.rst_n = r; s.mr = mr; s.z = z; s.op = op;
    e.st = st; e.ctl = model(st, mr, op, z); e.cnt = cnt_m;
    e.chk_b = chk_b; e.id = rec_id;
    rec_id++;
    stim_q.push_back(s);
    exp_q.push_back(e);
    if (!r) cnt_m = 16'd0;
    else if (st == LW_WB || st == R_WB || st == BRANCH || st == JUMP ||
             (st == MEM_WR && mr)) cnt_m = cnt_m + 16'd1;
  endtask

  task automatic fetch(input logic [3:0] op, input int waits);
    for (int i = 0; i < waits; i++) sched(FETCH, 1, 0, op, 0);
    sched(FETCH, 1, 1, op, 0);
    sched(DECODE, 1, 1, op, 0);
  endtask

  task automatic do_r(input logic [3:0] op);
    fetch(op, 0);
    sched(EXEC_R, 1, 1, op, 0);
    sched(R_WB, 1, 1, op, 0);
  endtask

  task automatic do_lw(input int fw, input int mw);
    fetch(4'h0, fw);
    sched(ADDR, 1, 1, 4'h0, 0);
    for (int i = 0; i < mw; i++) sched(MEM_RD, 1, 0, 4'h0, 0);
    sched(MEM_RD, 1, 1, 4'h0, 0);
    sched(LW_WB, 1, 1, 4'h0, 0);
  endtask

  task automatic do_sw();
    fetch(4'h1, 0);
    sched(ADDR, 1, 1, 4'h1, 0);
    sched(MEM_WR, 1, 1, 4'h1, 0);
  endtask

  task automatic do_br(input logic [3:0] op, input logic z);
    fetch(op, 0);
    sched(BRANCH, 1, 1, op, z);
  endtask

  task automatic do_j();
    fetch(4'hD, 0);
    sched(JUMP, 1, 1, 4'hD, 0);
  endtask

  task automatic chk(input string tag, input int id, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s rec=%0d observed=%h expected=%h", tag, id, got, exp);
    end
  endtask

  // Replays queued stimulus one cycle at a time; the matching expectation is
  // popped and compared mid-cycle, after inputs have settled.
  task automatic drain();
    stim_t s;
    exp_t  e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk);
      rst_n = s.rst_n; mem_ready = s.mr; zero = s.z; opcode = s.op;
      #1;
      e = exp_q.pop_front();
      chk("a_state", e.id, {12'd0, a_state}, {12'd0, e.st});
      chk("a_ctl",   e.id, {1'b0, a_ctl}, {1'b0, e.ctl});
      chk("a_count", e.id, a_count, e.cnt);
      if (e.chk_b) begin
        chk("b_state", e.id, {12'd0, b_state}, {12'd0, e.st});
        chk("b_ctl",   e.id, {1'b0, b_ctl}, {1'b0, e.ctl});
        chk("b_count", e.id, {14'd0, b_count}, {14'd0, e.cnt[1:0]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 4'h0;
    repeat (2) @(posedge clk);

    // reset state, then a mix of instructions
    sched(IDLE, 1, 1, 4'h2, 0);
    do_r(4'h2);
    do_lw(3, 2);
    do_sw();
    do_br(4'hB, 1);
    do_br(4'hC, 1);
    do_br(4'hB, 0);
    do_br(4'hC, 0);
    fetch(4'hF, 0);
    repeat (3) sched(HALT, 1, 1, 4'hF, 0);
    sched(HALT, 0, 1, 4'hF, 0);
    drain();

    // counter wrap on the narrow instance, then reset mid-load
    sched(IDLE, 1, 1, 4'hD, 0);
    repeat (5) do_j();
    fetch(4'h0, 0);
    sched(ADDR, 1, 1, 4'h0, 0);
    sched(MEM_RD, 1, 0, 4'h0, 0);
    sched(MEM_RD, 0, 0, 4'h0, 0);
    sched(IDLE, 1, 0, 4'h0, 0);
    drain();

    // illegal opcode
    fetch(4'hE, 0);
    repeat (2) sched(FAULT, 1, 1, 4'hE, 0);
    sched(FAULT, 0, 1, 4'hE, 0);
    sched(IDLE, 1, 1, 4'h1, 0);
    drain();

    // store stalls past the 4-cycle limit on u_a only
    fetch(4'h1, 0);
    sched(ADDR, 1, 1, 4'h1, 0);
    chk_b = 1'b0;
    repeat (4) sched(MEM_WR, 1, 0, 4'h1, 0);
    repeat (2) sched(FAULT, 1, 0, 4'h1, 0);
    sched(FAULT, 0, 0, 4'h1, 0);
    chk_b = 1'b1;
    sched(IDLE, 1, 1, 4'h9, 0);
    do_r(4'h9);
    sched(FETCH, 1, 1, 4'h9, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the 16-bit RISC core, replacing the single-cycle decode with a state machine that sequences each instruction over several clocks. It talks to one shared instruction/data memory through a req/ready handshake, with a timeout. It drives the datapath's register, ALU, PC and IR enables from the decoded 4-bit opcode. It also provides sticky halt/fault status and a retired-instruction counter.

## Interface
- OPCODE_W, 4: opcode width; encodings below use the low 4 bits.
- CNT_W, 16: width of `instr_count`.
- TIMEOUT, 255: maximum wait cycles for `mem_ready` per access; 0 disables the timeout.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, mem_we, iord  out  1 each  memory request, write enable, address select (0 = PC, 1 = ALU result).
- ir_write, pc_write  out  1 each  IR load and PC load.
- pc_src  out  2  00 = PC+2, 01 = branch target, 10 = jump target.
- reg_w, reg_dst, mem_to_reg, alu_src  out  1 each  datapath controls, same meaning as in the single-cycle core.
- alu_op  out  2  00 = add (address), 01 = sub (compare), 10 = function taken from opcode.
- halted, fault  out  1 each  sticky status.
- state  out  4  current state encoding.
- instr_count  out  CNT_W  retired instructions, modulo 2^CNT_W.

## Operation
- Opcode map: 0 LW, 1 SW, 2–9 R-type, B BEQ, C BNE, D J, F HALT; A and E are illegal.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, ADDR 3, MEM_RD 4, LW_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, BRANCH 9, JUMP A, HALT B, FAULT C.
- Outputs not listed for a state are 0.
- IDLE: all outputs 0; always moves to FETCH.
- FETCH: mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00; go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no outputs. Dispatch:
  - LW/SW go to ADDR.
  - R-type goes to EXEC_R.
  - BEQ/BNE go to BRANCH.
  - J goes to JUMP.
  - HALT goes to HALT.
  - Illegal opcodes go to FAULT.
- ADDR: alu_src=1, alu_op=00. LW goes to MEM_RD; SW goes to MEM_WR.
- MEM_RD: mem_req=1, iord=1. On mem_ready go to LW_WB.
- LW_WB: reg_w=1, mem_to_reg=1, reg_dst=0; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH.
- EXEC_R: alu_op=10, alu_src=0; go to R_WB.
- R_WB: reg_w=1, reg_dst=1; go to FETCH.
- BRANCH: alu_op=01, pc_src=01.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
  - Go to FETCH.
- JUMP: pc_write=1, pc_src=10; go to FETCH.
- HALT: halted=1; stays until reset.
- FAULT: fault=1; stays until reset.
- Outputs are decoded from the state register. The only exceptions: FETCH ir_write/pc_write are qualified by mem_ready, and BRANCH pc_write is qualified by zero.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle the state waits without mem_ready.
  - If mem_ready is still low when the count reaches TIMEOUT, go to FAULT on that edge.
  - mem_ready in the same cycle as the limit wins: the access completes.
- instr_count increments on the edge leaving LW_WB, MEM_WR (completed), R_WB, BRANCH or JUMP. HALT and FAULT do not count. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: rst_n low at an edge sets state=IDLE, instr_count=0, wait counter=0, halted=0, fault=0.
  - All outputs are 0 while in IDLE.
  - The first FETCH is the second cycle after release.
- Reset asserted mid-access abandons the access: mem_req is 0 from the next cycle. There is no partial register write.
- Cycles per instruction with zero-wait memory (mem_ready high in the request cycle):
  - LW 5.
  - SW 4.
  - R-type 4.
  - BEQ/BNE/J 3.
  - HALT reaches HALT after 2 cycles.
- Each memory wait cycle adds exactly 1 to the totals above.
- mem_req holds high and iord/mem_we hold stable until the cycle mem_ready is seen.

## Test plan
- Reset then R-type (opcode 2), mem_ready always 1:
  - state sequence is 0,1,2,7,8,1.
  - reg_w=1 and reg_dst=1 only in R_WB.
  - instr_count=1.
- LW with 3 wait cycles in FETCH and 2 in MEM_RD:
  - total is 10 cycles.
  - mem_req stays continuously high during the waits.
  - LW_WB has reg_w=1 and mem_to_reg=1.
- BEQ with zero=1 gives pc_write=1, pc_src=01 in BRANCH. BNE with zero=1 gives pc_write=0. Both increment instr_count.
- TIMEOUT=4 with mem_ready stuck low in MEM_WR:
  - FAULT is entered after 4 wait cycles; fault=1, mem_req=0.
  - The state is held until rst_n is pulsed low, which returns to IDLE.
- Opcode 0xE goes to FAULT from DECODE. Opcode 0xF sets halted=1 and holds it. instr_count is unchanged in both cases.
- CNT_W=2:
  - 5 back-to-back J instructions leave instr_count at 1, showing wrap.
  - rst_n low mid-MEM_RD drops mem_req the next cycle, and the count clears.
